pipe_hazard_ctrl: RTL

Central hazard, forwarding and exception sequencer for the 5-stage MIPS core. Generates stall, flush, forwarding-select and PC-source controls for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It also tracks the multi-cycle mult/div unit and latches pending interrupts until a valid instruction reaches MEM. Most outputs are combinational from its inputs and three state elements: the mult/div counter, the interrupt latch and the exception FSM.

---
 rtl/cpu_pkg.sv | 67 ++++++
 rtl/md_busy_counter.sv | 39 +++
 rtl/pipe_hazard_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the pipeline hazard/forwarding/exception control.
// Holds the PC-source and forwarding-select encodings, the exception FSM
// state type, and small helpers for forwarding and data-hazard detection.
package cpu_pkg;

  typedef enum logic [1:0] {
    PCSEL_SEQ = 2'd0,
    PCSEL_EXC = 2'd1,
    PCSEL_EPC = 2'd2
  } pc_sel_e;

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_M  = 2'd1,
    FWD_W  = 2'd2
  } fwd_e;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_EXC  = 2'd1,
    ST_ERET = 2'd2
  } exc_state_e;

  // Forwarding source for one operand. MEM is used only when its result was
  // produced in EX (so it already sits in EX/MEM); WB is the fallback.
  function automatic fwd_e fwd_sel(
    input logic [4:0] ra,
    input logic       use_m,
    input logic       wr_m,
    input logic [4:0] waddr_m,
    input logic       ready_m,
    input logic       wr_w,
    input logic [4:0] waddr_w
  );
    fwd_e sel;
    sel = FWD_RF;
    if (ra != '0) begin
      if (use_m && wr_m && (waddr_m == ra) && ready_m)
        sel = FWD_M;
      else if (wr_w && (waddr_w == ra))
        sel = FWD_W;
    end
    return sel;
  endfunction

  // Stall when a pending producer in EX or MEM will not have its result
  // ready by the time this source is consumed (Tnew > Tuse).
  function automatic logic data_hazard(
    input logic [4:0] ra,
    input logic [1:0] tuse,
    input logic       wr_e,
    input logic [4:0] waddr_e,
    input logic [1:0] tnew_e,
    input logic       wr_m,
    input logic [4:0] waddr_m,
    input logic [1:0] tnew_m
  );
    logic hz;
    hz = 1'b0;
    if (ra != '0) begin
      if (wr_e && (waddr_e == ra) && (tnew_e > tuse)) hz = 1'b1;
      if (wr_m && (waddr_m == ra) && (tnew_m > tuse)) hz = 1'b1;
    end
    return hz;
  endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Occupancy counter for the multi-cycle mult/div unit.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   i_start     - mult/div issued from EX this cycle
//   i_is_div    - the issued op is a divide
//   i_abort     - exception entry; discards any operation in flight
//   o_busy      - unit occupied (counter nonzero), forced low during reset
module md_busy_counter #(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic i_start,
  input  logic i_is_div,
  input  logic i_abort,
  output logic o_busy
);

  localparam int unsigned MAXC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int unsigned CW   = $clog2(MAXC + 1);

  logic [CW-1:0] r_cnt;

  // Abort outranks a simultaneous start so an excepting op never lingers.
  always_ff @(posedge clk) begin
    if (reset)
      r_cnt <= '0;
    else if (i_abort)
      r_cnt <= '0;
    else if (i_start)
      r_cnt <= i_is_div ? CW'(DIV_CYC) : CW'(MULT_CYC);
    else if (r_cnt != '0)
      r_cnt <= r_cnt - CW'(1);
  end

  assign o_busy = (r_cnt != '0) && !reset;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and exception sequencer for the 5-stage pipeline.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   RA*_D / UseAtD*_D / MD_D   - ID-stage sources and their consumption stage
//   Waddr_*/WriteReg_*         - destination and write enable per stage
//   WriteAt*_E/WriteAt*_M      - stage in which EX/MEM results are produced
//   RA1_E, RA2_E, RA2_M        - EX sources and MEM store-data source
//   MDStart_E, MDIsDiv_E       - mult/div issue from EX
//   ExcCode_M, eret_M, Valid_M - MEM-stage exception information
//   int_req                    - masked interrupt request
//   stall_F/D, flush_D/E/M/W   - pipeline register controls
//   PC_sel, exc_take           - PC source and CP0 capture strobe
//   Fwd*                       - forwarding selects (0 RF, 1 EX/MEM, 2 MEM/WB)
//   md_busy                    - mult/div unit occupied
module pipe_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned MULT_CYC = 5,
  parameter int unsigned DIV_CYC  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] RA1_D,
  input  logic [4:0] RA2_D,
  input  logic       UseAtD1_D,
  input  logic       UseAtD2_D,
  input  logic       MD_D,
  input  logic [4:0] Waddr_E,
  input  logic [4:0] Waddr_M,
  input  logic [4:0] Waddr_W,
  input  logic       WriteReg_E,
  input  logic       WriteReg_M,
  input  logic       WriteReg_W,
  input  logic       WriteAtE_E,
  input  logic       WriteAtM_E,
  input  logic       WriteAtW_E,
  input  logic       WriteAtE_M,
  input  logic       WriteAtM_M,
  input  logic       WriteAtW_M,
  input  logic [4:0] RA1_E,
  input  logic [4:0] RA2_E,
  input  logic [4:0] RA2_M,
  input  logic       MDStart_E,
  input  logic       MDIsDiv_E,
  input  logic [4:0] ExcCode_M,
  input  logic       eret_M,
  input  logic       Valid_M,
  input  logic       int_req,
  output logic       stall_F,
  output logic       stall_D,
  output logic       flush_D,
  output logic       flush_E,
  output logic       flush_M,
  output logic       flush_W,
  output logic [1:0] PC_sel,
  output logic       exc_take,
  output logic [1:0] FwdA_D,
  output logic [1:0] FwdB_D,
  output logic [1:0] FwdA_E,
  output logic [1:0] FwdB_E,
  output logic [1:0] FwdB_M,
  output logic       md_busy
);

  exc_state_e r_state;
  exc_state_e w_state_nxt;
  logic       r_int_pend;
  logic       w_int_take;
  logic       w_exc_det;
  logic       w_eret_det;
  logic       w_data_stall;
  logic       w_md_stall;
  logic       w_stall;
  logic       w_flush_all;
  logic [1:0] w_tnew_e;
  logic [1:0] w_tnew_m;
  logic [1:0] w_tuse1;
  logic [1:0] w_tuse2;
  logic       w_unused;

  // The later-stage producer flags only matter through WriteAtE_*.
  assign w_unused = ^{WriteAtM_E, WriteAtW_E, WriteAtM_M, WriteAtW_M};

  // ---------------- exception FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = ST_RUN;
    w_exc_det   = 1'b0;
    w_eret_det  = 1'b0;
    w_int_take  = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (!reset) begin
          w_int_take = r_int_pend && Valid_M;
          if ((ExcCode_M != '0) || w_int_take) begin
            w_exc_det   = 1'b1;
            w_state_nxt = ST_EXC;
          end else if (eret_M) begin
            w_eret_det  = 1'b1;
            w_state_nxt = ST_ERET;
          end
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // Pending interrupt: consumed on the edge it is taken, otherwise sticky.
  always_ff @(posedge clk) begin
    if (reset)           r_int_pend <= 1'b0;
    else if (w_int_take) r_int_pend <= 1'b0;
    else if (int_req)    r_int_pend <= 1'b1;
  end

  // ---------------- mult/div occupancy ----------------
  md_busy_counter #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC)
  ) u_md_cnt (
    .clk      (clk),
    .reset    (reset),
    .i_start  (MDStart_E),
    .i_is_div (MDIsDiv_E),
    .i_abort  (w_exc_det),
    .o_busy   (md_busy)
  );

  // ---------------- stall logic ----------------
  assign w_tnew_e = WriteAtE_E ? 2'd1 : 2'd2;
  assign w_tnew_m = WriteAtE_M ? 2'd0 : 2'd1;
  assign w_tuse1  = UseAtD1_D ? 2'd0 : 2'd1;
  assign w_tuse2  = UseAtD2_D ? 2'd0 : 2'd1;

  assign w_data_stall =
    data_hazard(RA1_D, w_tuse1, WriteReg_E, Waddr_E, w_tnew_e, WriteReg_M, Waddr_M, w_tnew_m) ||
    data_hazard(RA2_D, w_tuse2, WriteReg_E, Waddr_E, w_tnew_e, WriteReg_M, Waddr_M, w_tnew_m);
  assign w_md_stall   = MD_D && (md_busy || MDStart_E);

  // A redirect flushes the whole pipe, so any stall that cycle is moot.
  assign w_stall     = !reset && !w_exc_det && !w_eret_det && (w_data_stall || w_md_stall);
  assign w_flush_all = reset || w_exc_det || w_eret_det;

  assign stall_F = w_stall;
  assign stall_D = w_stall;
  assign flush_D = w_flush_all;
  assign flush_E = w_flush_all || w_stall;
  assign flush_M = w_flush_all;
  assign flush_W = w_flush_all;

  assign PC_sel   = w_exc_det  ? PCSEL_EXC :
                    w_eret_det ? PCSEL_EPC : PCSEL_SEQ;
  assign exc_take = w_exc_det;

  // ---------------- forwarding ----------------
  always_comb begin
    FwdA_D = FWD_RF;
    FwdB_D = FWD_RF;
    FwdA_E = FWD_RF;
    FwdB_E = FWD_RF;
    FwdB_M = FWD_RF;
    if (!reset) begin
      FwdA_D = fwd_sel(RA1_D, 1'b1, WriteReg_M, Waddr_M, WriteAtE_M, WriteReg_W, Waddr_W);
      FwdB_D = fwd_sel(RA2_D, 1'b1, WriteReg_M, Waddr_M, WriteAtE_M, WriteReg_W, Waddr_W);
      FwdA_E = fwd_sel(RA1_E, 1'b1, WriteReg_M, Waddr_M, WriteAtE_M, WriteReg_W, Waddr_W);
      FwdB_E = fwd_sel(RA2_E, 1'b1, WriteReg_M, Waddr_M, WriteAtE_M, WriteReg_W, Waddr_W);
      FwdB_M = fwd_sel(RA2_M, 1'b0, WriteReg_M, Waddr_M, WriteAtE_M, WriteReg_W, Waddr_W);
    end
  end

endmodule
